// File: rtl/bp_update_ctrl.sv
// Branch-predictor update scheduler: accepts up to two resolved branches per
// cycle in program order, buffers them in a small FIFO and drains one update
// per cycle into the predictor through a registered output stage, while
// keeping saturating branch/mispredict statistics.
module bp_update_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned CNTW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_ready,
  input  logic            req0_valid,
  input  logic            req0_taken,
  input  logic            req0_fail,
  input  logic [AW-1:0]   req0_addr,
  input  logic [AW-1:0]   req0_target,
  input  logic            req1_valid,
  input  logic            req1_taken,
  input  logic            req1_fail,
  input  logic [AW-1:0]   req1_addr,
  input  logic [AW-1:0]   req1_target,
  input  logic            freeze,
  input  logic            clr_stats,
  output logic            branch,
  output logic            branch_res,
  output logic            branch_fail,
  output logic [AW-1:0]   branch_addr,
  output logic [AW-1:0]   branch_target,
  output logic            empty,
  output logic [CNTW-1:0] br_cnt,
  output logic [CNTW-1:0] miss_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic          taken;
    logic          fail;
    logic [AW-1:0] addr;
    logic [AW-1:0] target;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [1:0]    w_n_enq;
  logic          w_deq;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_tail1;
  entry_t        w_e0;
  entry_t        w_e1;

  // Enqueue/dequeue decisions and next occupancy
  always_comb begin
    w_e0         = '{taken: req0_taken, fail: req0_fail, addr: req0_addr, target: req0_target};
    w_e1         = '{taken: req1_taken, fail: req1_fail, addr: req1_addr, target: req1_target};
    w_n_enq      = req_ready ? ({1'b0, req0_valid} + {1'b0, req1_valid}) : 2'd0;
    w_deq        = !freeze && (r_count != '0);
    w_count_next = r_count + CW'(w_n_enq) - CW'(w_deq);
    w_tail1      = r_tail + PW'(1);
  end

  // Payload storage; requests while not ready are dropped
  always_ff @(posedge clk) begin
    if (req_ready) begin
      if (req0_valid) begin
        r_mem[r_tail] <= w_e0;
        if (req1_valid) r_mem[w_tail1] <= w_e1;
      end else if (req1_valid) begin
        r_mem[r_tail] <= w_e1;
      end
    end
  end

  // Pointers, occupancy, registered ready and the predictor output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      req_ready     <= 1'b1;
      branch        <= 1'b0;
      branch_res    <= 1'b0;
      branch_fail   <= 1'b0;
      branch_addr   <= '0;
      branch_target <= '0;
    end else begin
      r_tail    <= r_tail + PW'(w_n_enq);
      r_count   <= w_count_next;
      // two free slots needed so a two-wide request never overruns
      req_ready <= (w_count_next <= CW'(DEPTH - 2));
      branch    <= w_deq;
      if (w_deq) begin
        r_head        <= r_head + PW'(1);
        branch_res    <= r_mem[r_head].taken;
        branch_fail   <= r_mem[r_head].fail;
        branch_addr   <= r_mem[r_head].addr;
        branch_target <= r_mem[r_head].target;
      end
    end
  end

  // Saturating statistics over updates presented to the predictor
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (branch) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNTW'(1);
      if (branch_fail && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNTW'(1);
    end
  end

  assign empty = (r_count == '0) && !branch;

endmodule
